fpdiv_iter: RTL and testbench
=============================

Name: fpdiv_iter

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point divider.
- Successor to the single-precision fpdiv datapath. Adds:
  - configurable exponent and mantissa widths
  - a START/BUSY/DONE handshake
  - iterative restoring mantissa division
  - normalisation, special-operand handling and exception reporting
- Sits between the operand registers and the result writeback in the FP unit. Computes AbyB = InputA / InputB.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored fraction width in bits; total word width is 1+EXP_W+MAN_W.

Ports:
- CLOCK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled only while BUSY=0.
- InputA  input  1+EXP_W+MAN_W  dividend: {sign, exp, frac}.
- InputB  input  1+EXP_W+MAN_W  divisor: same format.
- AbyB  output  1+EXP_W+MAN_W  quotient; held until the next accepted START.
- BUSY  output  1  high while an operation is in flight.
- DONE  output  1  one-cycle pulse when AbyB/EXCEPTION are valid.
- EXCEPTION  output  2  00 none, 01 invalid or divide-by-zero, 10 overflow, 11 underflow.

Behaviour:
- Reset (RESET=0, any time, including mid-operation):
  - state=IDLE; AbyB=0, EXCEPTION=00, BUSY=0, DONE=0.
  - All internal registers cleared; the in-flight result is discarded.
- States: IDLE, DIVIDE, NORM, FINISH.
  - BUSY = (state==DIVIDE or NORM).
  - DONE = (state==FINISH).
- Accept: in IDLE or FINISH with START=1 at edge t, InputA/InputB are latched.
  - START while BUSY=1 is ignored; no queueing.
- Operand classification at accept:
  - exp==0 is zero; subnormals are flushed to zero.
  - exp==all-ones with frac==0 is inf; exp==all-ones with frac!=0 is NaN.
- Sign: result sign = signA xor signB, for every case except NaN.
- Special cases go straight to FINISH; DONE is high in cycle t+1:
  - Either operand NaN, 0/0, or inf/inf: AbyB = canonical qNaN {0, all-ones, 1 followed by zeros}, EXCEPTION=01.
  - finite/0: signed inf, EXCEPTION=01.
  - inf/finite: signed inf, EXCEPTION=00.
  - finite/inf or 0/finite: signed zero, EXCEPTION=00.
- Normal path:
  - DIVIDE runs MAN_W+2 cycles. Restoring division of {1,fracA} by {1,fracB}, one quotient bit per cycle, producing Q[MAN_W+1:0] covering weights 2^0..2^-(MAN_W+1).
  - NORM takes 1 cycle:
    - If Q[MAN_W+1]=0, shift Q left by 1 and decrement the exponent.
    - Fraction = next MAN_W bits below the leading 1, truncated (round toward zero).
  - FINISH: DONE high at cycle t+MAN_W+4 (27 for defaults). Next state IDLE unless a new START is accepted.
- Exponent arithmetic:
  - Computed in EXP_W+2-bit signed: e = eA - eB + BIAS (-1 if normalised), where BIAS = 2^(EXP_W-1)-1.
  - e >= 2^EXP_W-1: signed inf, EXCEPTION=10.
  - e <= 0: signed zero, EXCEPTION=11.
- Back-to-back operation: START in the FINISH cycle is accepted; DONE drops the next cycle and BUSY rises.

Decomposition:
- Shared package fpdiv_pkg holds:
  - EXCEPTION code constants (EXC_NONE, EXC_INVALID, EXC_OVF, EXC_UNF)
  - state encoding
  - functions for BIAS and canonical qNaN as a function of EXP_W/MAN_W
- Sub-module fpdiv_restoring_core (parameter MAN_W):
  - Ports: CLOCK, RESET, load, dividend/divisor mantissas, busy, quotient.
  - Performs the iterative bit-serial divide.
- The top level holds the FSM, classification, exponent path and normalisation.

Test Plan:
- Basic divide: 0x40C00000 / 0x40000000 (6/2), START at t -> BUSY t+1..t+26, DONE at t+27, AbyB=0x40400000, EXCEPTION=00.
- Normalise and truncate: 0x3F800000 / 0x40400000 (1/3) -> AbyB=0x3EAAAAAA, EXCEPTION=00. Same with InputA=0xBF800000 -> 0xBEAAAAAA.
- Special operands:
  - 0x3F800000 / 0x00000000 -> DONE at t+1, AbyB=0x7F800000, EXCEPTION=01.
  - 0x00000000 / 0x00000000 -> AbyB=0x7FC00000, EXCEPTION=01.
  - 0x7F800000 / 0x40000000 -> 0x7F800000, EXCEPTION=00.
- Range limits:
  - 0x7F000000 / 0x00800000 -> AbyB=0x7F800000, EXCEPTION=10.
  - 0x00800000 / 0x7F000000 -> AbyB=0x00000000, EXCEPTION=11.
- Handshake:
  - START re-asserted during BUSY is ignored; the original result is unchanged.
  - START in the FINISH cycle is accepted, DONE pulses exactly once per operation, and the second result matches its operands.
- Reset mid-DIVIDE: RESET low at cycle t+10 -> outputs 0 immediately (asynchronous), no DONE pulse. After RESET is released, a new 6/2 operation completes correctly in 27 cycles.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// ============================================================================
// Module      : fpdiv_pkg
// Description : Shared exception codes, FSM encoding and format helpers for
//               the iterative floating-point divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpdiv_pkg;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_INVALID = 2'b01;
    localparam logic [1:0] EXC_OVF     = 2'b10;
    localparam logic [1:0] EXC_UNF     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_NORM   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic int fpdiv_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Wide enough for any practical format; callers truncate to their word width.
    function automatic logic [127:0] fpdiv_qnan(input int exp_w, input int man_w);
        logic [127:0] v;
        v = ((128'd1 << exp_w) - 128'd1) << man_w;
        v = v | (128'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpdiv_restoring_core.sv
// ============================================================================
// Module      : fpdiv_restoring_core
// Description : Bit-serial restoring divider for normalised mantissas,
//               one quotient bit per cycle, MAN_W+2 bits in total.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpdiv_restoring_core #(
    parameter int MAN_W = 23
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             load,
    input  logic [MAN_W:0]   dividend,
    input  logic [MAN_W:0]   divisor,
    output logic             busy,
    output logic [MAN_W+1:0] quotient
);

    localparam int c_cw = $clog2(MAN_W + 3);

    logic [MAN_W+1:0] r_rem;
    logic [MAN_W:0]   r_div;
    logic [MAN_W+1:0] r_q;
    logic [c_cw-1:0]  r_cnt;

    logic [MAN_W+1:0] w_rem_in;
    logic [MAN_W:0]   w_div_in;
    logic             w_ge;
    logic [MAN_W+1:0] w_diff;
    logic [MAN_W+1:0] w_rem_nxt;

    // The load cycle already produces the first quotient bit, so the core
    // finishes one cycle before the controller leaves its divide state.
    assign w_rem_in  = load ? {1'b0, dividend} : r_rem;
    assign w_div_in  = load ? divisor : r_div;
    assign w_ge      = (w_rem_in >= {1'b0, w_div_in});
    assign w_diff    = w_ge ? (w_rem_in - {1'b0, w_div_in}) : w_rem_in;
    assign w_rem_nxt = w_diff << 1;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_rem <= '0;
            r_div <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_rem <= w_rem_nxt;
            r_div <= divisor;
            r_q   <= {{(MAN_W+1){1'b0}}, w_ge};
            r_cnt <= c_cw'(MAN_W + 1);
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[MAN_W:0], w_ge};
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign busy     = (r_cnt != '0);
    assign quotient = r_q;

endmodule

`default_nettype wire

// File: rtl/fpdiv_iter.sv
// ============================================================================
// Module      : fpdiv_iter
// Description : Multi-cycle IEEE-754-style divider with START/BUSY/DONE
//               handshake, special-operand handling and exception codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpdiv_iter
    import fpdiv_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   CLOCK,
    input  logic                   RESET,
    input  logic                   START,
    input  logic [EXP_W+MAN_W:0]   InputA,
    input  logic [EXP_W+MAN_W:0]   InputB,
    output logic [EXP_W+MAN_W:0]   AbyB,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [1:0]             EXCEPTION
);

    localparam int c_w  = 1 + EXP_W + MAN_W;
    localparam int c_ew = EXP_W + 2;
    localparam logic [c_w-1:0]         c_qnan    = c_w'(fpdiv_qnan(EXP_W, MAN_W));
    localparam logic signed [c_ew-1:0] c_bias    = c_ew'(fpdiv_bias(EXP_W));
    localparam logic signed [c_ew-1:0] c_exp_max = c_ew'((1 << EXP_W) - 1);

    state_t                  r_state;
    logic [c_w-1:0]          r_abyb;
    logic [1:0]              r_exc;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_sign;
    logic signed [c_ew-1:0]  r_exp;

    logic                    w_sa, w_sb, w_sign;
    logic [EXP_W-1:0]        w_ea, w_eb;
    logic [MAN_W-1:0]        w_fa, w_fb;
    logic                    w_a_zero, w_a_inf, w_a_nan;
    logic                    w_b_zero, w_b_inf, w_b_nan;
    logic                    w_accept, w_load;
    logic                    w_special;
    logic [c_w-1:0]          w_spec_res;
    logic [1:0]              w_spec_exc;
    logic signed [c_ew-1:0]  w_exp_base;
    logic                    w_core_busy;
    logic [MAN_W+1:0]        w_q;
    logic                    w_lead;
    logic [MAN_W-1:0]        w_frac;
    logic signed [c_ew-1:0]  w_exp_fin;
    logic [c_w-1:0]          w_norm_res;
    logic [1:0]              w_norm_exc;

    assign {w_sa, w_ea, w_fa} = InputA;
    assign {w_sb, w_eb, w_fb} = InputB;
    assign w_sign = w_sa ^ w_sb;

    // Subnormals are flushed to zero by classifying on the exponent alone.
    assign w_a_zero = (w_ea == '0);
    assign w_a_inf  = (w_ea == '1) && (w_fa == '0);
    assign w_a_nan  = (w_ea == '1) && (w_fa != '0);
    assign w_b_zero = (w_eb == '0);
    assign w_b_inf  = (w_eb == '1) && (w_fb == '0);
    assign w_b_nan  = (w_eb == '1) && (w_fb != '0);

    assign w_accept = START && ((r_state == ST_IDLE) || (r_state == ST_FINISH));
    assign w_load   = w_accept && !w_special;

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = '0;
        w_spec_exc = EXC_NONE;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_spec_res = c_qnan;
            w_spec_exc = EXC_INVALID;
        end else if (w_a_inf) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (w_b_zero) begin
            w_spec_res = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_spec_exc = EXC_INVALID;
        end else if (w_b_inf || w_a_zero) begin
            w_spec_res = {w_sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            w_special = 1'b0;
        end
    end

    assign w_exp_base = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + c_bias;

    fpdiv_restoring_core #(
        .MAN_W (MAN_W)
    ) u_core (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .load     (w_load),
        .dividend ({1'b1, w_fa}),
        .divisor  ({1'b1, w_fb}),
        .busy     (w_core_busy),
        .quotient (w_q)
    );

    // A quotient below 1.0 has its leading one one place lower.
    assign w_lead    = w_q[MAN_W+1];
    assign w_frac    = w_lead ? w_q[MAN_W:1] : w_q[MAN_W-1:0];
    assign w_exp_fin = r_exp - $signed({{(c_ew-1){1'b0}}, ~w_lead});

    always_comb begin
        w_norm_res = {r_sign, w_exp_fin[EXP_W-1:0], w_frac};
        w_norm_exc = EXC_NONE;
        if (w_exp_fin >= c_exp_max) begin
            w_norm_res = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_norm_exc = EXC_OVF;
        end else if (w_exp_fin <= 0) begin
            w_norm_res = {r_sign, {(EXP_W+MAN_W){1'b0}}};
            w_norm_exc = EXC_UNF;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_abyb  <= '0;
            r_exc   <= EXC_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sign  <= 1'b0;
            r_exp   <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_FINISH: begin
                    if (w_accept && w_special) begin
                        r_state <= ST_FINISH;
                        r_abyb  <= w_spec_res;
                        r_exc   <= w_spec_exc;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_accept) begin
                        r_state <= ST_DIVIDE;
                        r_sign  <= w_sign;
                        r_exp   <= w_exp_base;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_DIVIDE: begin
                    if (!w_core_busy) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_state <= ST_FINISH;
                    r_abyb  <= w_norm_res;
                    r_exc   <= w_norm_exc;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign AbyB      = r_abyb;
    assign EXCEPTION = r_exc;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fpdiv_iter.sv
// ============================================================================
// Module      : tb_fpdiv_iter
// Description : Self-checking bench for fpdiv_iter (single-precision format)
//               against an integer-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpdiv_iter;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        START;
    logic [31:0] InputA;
    logic [31:0] InputB;
    logic [31:0] AbyB;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  EXCEPTION;

    int total = 0;
    int bad   = 0;

    fpdiv_iter #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .START     (START),
        .InputA    (InputA),
        .InputB    (InputB),
        .AbyB      (AbyB),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .EXCEPTION (EXCEPTION)
    );

    always #5 CLOCK = ~CLOCK;

    // Quotient taken as floor(A/B * 2^24) on the full significands.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [1:0] e);
        logic   sign;
        int     ea, eb, ex;
        longint ma, mb, q, frac;
        bit     az, ai, an, bz, bi, bn;
        sign = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        az = (ea == 0);
        ai = (ea == 255) && (a[22:0] == 0);
        an = (ea == 255) && (a[22:0] != 0);
        bz = (eb == 0);
        bi = (eb == 255) && (b[22:0] == 0);
        bn = (eb == 255) && (b[22:0] != 0);
        e = 2'b00;
        if (an || bn || (az && bz) || (ai && bi)) begin
            r = 32'h7FC00000; e = 2'b01;
        end else if (ai) begin
            r = {sign, 31'h7F800000};
        end else if (bz) begin
            r = {sign, 31'h7F800000}; e = 2'b01;
        end else if (bi || az) begin
            r = {sign, 31'h0};
        end else begin
            ma = longint'(a[22:0]) + 64'd8388608;
            mb = longint'(b[22:0]) + 64'd8388608;
            q  = (ma * 64'd16777216) / mb;
            ex = ea - eb + 127;
            if (q >= 64'd16777216) begin
                frac = (q / 2) % 64'd8388608;
            end else begin
                frac = q % 64'd8388608;
                ex   = ex - 1;
            end
            if (ex >= 255) begin
                r = {sign, 31'h7F800000}; e = 2'b10;
            end else if (ex <= 0) begin
                r = {sign, 31'h0}; e = 2'b11;
            end else begin
                r = {sign, 8'(ex), 23'(frac)};
            end
        end
    endfunction

    // Caller is positioned at a falling edge; returns just after the accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        InputA = a;
        InputB = b;
        START  = 1'b1;
        @(posedge CLOCK);
        #1 START = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLOCK);
            lat++;
            if (DONE) break;
            if (BUSY) busy_n++;
        end
        total++;
        if (!DONE) begin
            bad++;
            $display("FAIL done_timeout: no DONE within %0d cycles", lat);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; START = 1'b0; InputA = '0; InputB = '0;
        #12;
        total++; if (AbyB !== 32'h0) begin bad++; $display("FAIL reset_abyb: got %h want 0", AbyB); end
        total++; if (EXCEPTION !== 2'b00) begin bad++; $display("FAIL reset_exc: got %b want 00", EXCEPTION); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", DONE); end
        @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h3F800000,
                                32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000};
        logic [31:0] tb [8] = '{32'h40000000, 32'h40400000, 32'h40400000, 32'h00000000,
                                32'h00000000, 32'h40000000, 32'h00800000, 32'h7F000000};
        logic [31:0] tr [8] = '{32'h40400000, 32'h3EAAAAAA, 32'hBEAAAAAA, 32'h7F800000,
                                32'h7FC00000, 32'h7F800000, 32'h7F800000, 32'h00000000};
        logic [1:0]  te [8] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b11};
        int          tl [8] = '{27, 27, 27, 1, 1, 1, 27, 27};
        int lat, busy_n;
        for (int i = 0; i < 8; i++) begin
            start_op(ta[i], tb[i]);
            wait_done(lat, busy_n);
            total++; if (AbyB !== tr[i]) begin bad++; $display("FAIL dir%0d_abyb: got %h want %h", i, AbyB, tr[i]); end
            total++; if (EXCEPTION !== te[i]) begin bad++; $display("FAIL dir%0d_exc: got %b want %b", i, EXCEPTION, te[i]); end
            total++; if (lat != tl[i]) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
            total++; if (busy_n != tl[i] - 1) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, busy_n, tl[i] - 1); end
            @(negedge CLOCK);
        end
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] v;
        int kind;
        v = $urandom;
        kind = $urandom_range(0, 15);
        case (kind)
            0: v[30:0] = 31'h0;
            1: v[30:23] = 8'h00;
            2: v[30:0] = 31'h7F800000;
            3: v[30:23] = 8'hFF;
            default: v[30:23] = 8'($urandom_range(1, 254));
        endcase
        return v;
    endfunction

    task automatic test_random();
        logic [31:0] a, b, r;
        logic [1:0]  e;
        int lat, busy_n;
        for (int i = 0; i < 40; i++) begin
            a = rand_operand();
            b = rand_operand();
            if (i % 2 == 0) b[30:23] = 8'($urandom_range(100, 154));
            model(a, b, r, e);
            start_op(a, b);
            wait_done(lat, busy_n);
            total++; if (AbyB !== r) begin bad++; $display("FAIL rnd_abyb: %h/%h got %h want %h", a, b, AbyB, r); end
            total++; if (EXCEPTION !== e) begin bad++; $display("FAIL rnd_exc: %h/%h got %b want %b", a, b, EXCEPTION, e); end
            @(negedge CLOCK);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, busy_n;
        @(negedge CLOCK);
        start_op(32'h40C00000, 32'h40000000);
        repeat (5) @(negedge CLOCK);
        start_op(32'h3F800000, 32'h40400000);
        InputA = 32'h12345678;
        InputB = 32'h3F000000;
        wait_done(lat, busy_n);
        total++; if (AbyB !== 32'h40400000) begin bad++; $display("FAIL busy_ignore_abyb: got %h want 40400000", AbyB); end
        total++; if (lat != 22) begin bad++; $display("FAIL busy_ignore_latency: got %0d want 22", lat); end
        @(negedge CLOCK);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [1:0]  e;
        logic [31:0] a2, b2;
        int lat, busy_n;
        a2 = 32'h3FC00000 | ($urandom & 32'h007FFFFF);
        b2 = 32'h40100000 | ($urandom & 32'h007FFFFF);
        model(a2, b2, r, e);
        start_op(32'h3F800000, 32'h40400000);
        wait_done(lat, busy_n);
        total++; if (AbyB !== 32'h3EAAAAAA) begin bad++; $display("FAIL b2b_first_abyb: got %h want 3EAAAAAA", AbyB); end
        start_op(a2, b2);
        wait_done(lat, busy_n);
        total++; if (lat != 27) begin bad++; $display("FAIL b2b_latency: got %0d want 27", lat); end
        total++; if (busy_n != 26) begin bad++; $display("FAIL b2b_busy_cycles: got %0d want 26", busy_n); end
        total++; if (AbyB !== r) begin bad++; $display("FAIL b2b_second_abyb: got %h want %h", AbyB, r); end
        total++; if (EXCEPTION !== e) begin bad++; $display("FAIL b2b_second_exc: got %b want %b", EXCEPTION, e); end
        @(negedge CLOCK);
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL b2b_single_pulse: DONE got %b want 0", DONE); end
    endtask

    task automatic test_reset_mid();
        int lat, busy_n, spurious;
        @(negedge CLOCK);
        start_op(32'h40C00000, 32'h40000000);
        repeat (9) @(negedge CLOCK);
        #2 RESET = 1'b0;
        #1;
        total++; if (AbyB !== 32'h0) begin bad++; $display("FAIL rstmid_abyb: got %h want 0", AbyB); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", BUSY); end
        total++; if (DONE !== 1'b0) begin bad++; $display("FAIL rstmid_done: got %b want 0", DONE); end
        total++; if (EXCEPTION !== 2'b00) begin bad++; $display("FAIL rstmid_exc: got %b want 00", EXCEPTION); end
        @(negedge CLOCK);
        RESET = 1'b1;
        spurious = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLOCK);
            if (DONE || BUSY) spurious++;
        end
        total++; if (spurious != 0) begin bad++; $display("FAIL rstmid_no_done: activity cycles got %0d want 0", spurious); end
        start_op(32'h40C00000, 32'h40000000);
        wait_done(lat, busy_n);
        total++; if (lat != 27) begin bad++; $display("FAIL rstmid_latency: got %0d want 27", lat); end
        total++; if (AbyB !== 32'h40400000) begin bad++; $display("FAIL rstmid_abyb_after: got %h want 40400000", AbyB); end
        total++; if (EXCEPTION !== 2'b00) begin bad++; $display("FAIL rstmid_exc_after: got %b want 00", EXCEPTION); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
